// File: rtl/clock_pkg.sv
// Shared widths, limits and alarm state encoding for the clock timekeeper.
package clock_pkg;

  localparam int HOUR_W = 4;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam int HOURS_MAX = 11;
  localparam int MIN_MAX   = 59;
  localparam int SEC_MAX   = 59;

  // Wide enough for RING_SECONDS up to 255.
  localparam int RING_W = 8;

  typedef enum logic [1:0] {
    AL_OFF,
    AL_ARMED,
    AL_RINGING
  } al_state_e;

  function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
    return (h == HOUR_W'(HOURS_MAX)) ? '0 : h + HOUR_W'(1);
  endfunction

endpackage

// File: rtl/clock_timekeeper_mod_counter.sv
// Modulo-N up counter with a look-ahead next value, so the parent can compare
// the post-update time in the same cycle it is committed.
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int W       = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         carry_out
);

  logic wrap;

  always_comb begin
    wrap       = (count == W'(MODULUS - 1));
    carry_out  = inc & wrap;
    count_next = count;
    if (inc) begin
      count_next = wrap ? '0 : count + W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment so every register samples
  // pre-edge values, independent of the order the always blocks run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// 12-hour timekeeper with alarm setpoint, alarm FSM (auto-timeout) and gated
// buzzer. Every output is a flop.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int RING_SECONDS = 60,
  parameter int AL_STEP_MIN  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_tick,
  input  logic              tone_tick,
  input  logic              hrs_adj,
  input  logic              min_adj,
  input  logic              sec_adj,
  input  logic              al_adj,
  input  logic              al_toggle,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [HOUR_W-1:0] al_hours,
  output logic [MIN_W-1:0]  al_minutes,
  output logic              al_on,
  output logic              ringing,
  output logic              buzzer
);

  // One time action per cycle; lower-priority pulses are dropped.
  logic time_upd, sec_inc, min_inc, hrs_inc;
  logic adj_min_sel, adj_hrs_sel;
  logic sec_carry, min_carry, hrs_carry_unused;
  logic [SEC_W-1:0]  sec_next;
  logic [MIN_W-1:0]  min_next;
  logic [HOUR_W-1:0] hrs_next;

  assign time_upd    = sec_tick | sec_adj | min_adj | hrs_adj;
  assign sec_inc     = sec_tick | sec_adj;
  assign adj_min_sel = ~sec_tick & ~sec_adj & min_adj;
  assign adj_hrs_sel = ~sec_tick & ~sec_adj & ~min_adj & hrs_adj;
  // Carries only ripple for a real second tick, never for a manual adjust.
  assign min_inc     = (sec_tick & sec_carry) | adj_min_sel;
  assign hrs_inc     = (sec_tick & min_carry) | adj_hrs_sel;

  mod_counter #(.MODULUS(SEC_MAX + 1), .W(SEC_W)) u_sec (
    .clk        (clk),
    .reset      (reset),
    .inc        (sec_inc),
    .count      (seconds),
    .count_next (sec_next),
    .carry_out  (sec_carry)
  );

  mod_counter #(.MODULUS(MIN_MAX + 1), .W(MIN_W)) u_min (
    .clk        (clk),
    .reset      (reset),
    .inc        (min_inc),
    .count      (minutes),
    .count_next (min_next),
    .carry_out  (min_carry)
  );

  mod_counter #(.MODULUS(HOURS_MAX + 1), .W(HOUR_W)) u_hrs (
    .clk        (clk),
    .reset      (reset),
    .inc        (hrs_inc),
    .count      (hours),
    .count_next (hrs_next),
    .carry_out  (hrs_carry_unused)
  );

  // Alarm setpoint: AL_STEP_MIN divides 60, so the sum lands exactly on 60.
  logic [MIN_W:0] al_min_sum;
  logic           al_min_wrap;

  assign al_min_sum  = {1'b0, al_minutes} + (MIN_W + 1)'(AL_STEP_MIN);
  assign al_min_wrap = (al_min_sum >= (MIN_W + 1)'(MIN_MAX + 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      al_hours   <= '0;
      al_minutes <= '0;
    end else if (al_adj) begin
      if (al_min_wrap) begin
        al_minutes <= '0;
        al_hours   <= hour_inc(al_hours);
      end else begin
        al_minutes <= al_min_sum[MIN_W-1:0];
      end
    end
  end

  // Match compares the time being committed this cycle, not the stale one.
  logic match;
  assign match = time_upd && (hrs_next == al_hours) &&
                 (min_next == al_minutes) && (sec_next == '0);

  al_state_e        state, state_next;
  logic [RING_W-1:0] ring_cnt;
  logic             ring_done;
  logic             ring_stay;
  logic             beat, tone, beat_next, tone_next;

  assign ring_done = sec_tick && (ring_cnt == RING_W'(RING_SECONDS - 1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      AL_OFF: begin
        if (al_toggle) state_next = AL_ARMED;
      end
      AL_ARMED: begin
        if (al_toggle)  state_next = AL_OFF;
        else if (match) state_next = AL_RINGING;
      end
      AL_RINGING: begin
        if (al_toggle)      state_next = AL_OFF;
        else if (ring_done) state_next = AL_ARMED;
      end
      default: state_next = AL_OFF;
    endcase
  end

  // Beat and tone only run while ringing continues; entry and exit clear them.
  always_comb begin
    ring_stay = (state == AL_RINGING) && (state_next == AL_RINGING);
    beat_next = 1'b0;
    tone_next = 1'b0;
    if (ring_stay) begin
      beat_next = beat ^ sec_tick;
      tone_next = tone ^ tone_tick;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= AL_OFF;
      ring_cnt <= '0;
      beat     <= 1'b0;
      tone     <= 1'b0;
      al_on    <= 1'b0;
      ringing  <= 1'b0;
      buzzer   <= 1'b0;
    end else begin
      state    <= state_next;
      ring_cnt <= ring_stay ? ring_cnt + RING_W'(sec_tick) : '0;
      beat     <= beat_next;
      tone     <= tone_next;
      al_on    <= (state_next != AL_OFF);
      ringing  <= (state_next == AL_RINGING);
      buzzer   <= beat_next & tone_next;
    end
  end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed scoreboard bench for clock_timekeeper: stimulus queues expected
// output snapshots, a negedge monitor pops and compares them.
module tb_clock_timekeeper;

  typedef struct packed {
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [3:0] al_hours;
    logic [5:0] al_minutes;
    logic       al_on;
    logic       ringing;
    logic       buzzer;
  } outs_t;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] ST   = 7'b1000000;
  localparam logic [6:0] TT   = 7'b0100000;
  localparam logic [6:0] HA   = 7'b0010000;
  localparam logic [6:0] MA   = 7'b0001000;
  localparam logic [6:0] SA   = 7'b0000100;
  localparam logic [6:0] AA   = 7'b0000010;
  localparam logic [6:0] AT   = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0, tone_tick = 1'b0, hrs_adj = 1'b0, min_adj = 1'b0;
  logic       sec_adj = 1'b0, al_adj = 1'b0, al_toggle = 1'b0;
  logic [3:0] hours, al_hours;
  logic [5:0] minutes, seconds, al_minutes;
  logic       al_on, ringing, buzzer;

  int    n_tests = 0;
  int    n_fail  = 0;
  string name_q[$];
  outs_t exp_q[$];

  always #5 clk = ~clk;

  clock_timekeeper #(.RING_SECONDS(3), .AL_STEP_MIN(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .sec_tick   (sec_tick),
    .tone_tick  (tone_tick),
    .hrs_adj    (hrs_adj),
    .min_adj    (min_adj),
    .sec_adj    (sec_adj),
    .al_adj     (al_adj),
    .al_toggle  (al_toggle),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .al_hours   (al_hours),
    .al_minutes (al_minutes),
    .al_on      (al_on),
    .ringing    (ringing),
    .buzzer     (buzzer)
  );

  function automatic outs_t mk(input int h, m, s, ah, am, input logic on, rg, bz);
    outs_t o;
    o.hours      = 4'(h);
    o.minutes    = 6'(m);
    o.seconds    = 6'(s);
    o.al_hours   = 4'(ah);
    o.al_minutes = 6'(am);
    o.al_on      = on;
    o.ringing    = rg;
    o.buzzer     = bz;
    return o;
  endfunction

  // One clock cycle with the given pulses; pulses drop 1 ns after the edge.
  task automatic cyc(input logic [6:0] p);
    {sec_tick, tone_tick, hrs_adj, min_adj, sec_adj, al_adj, al_toggle} = p;
    @(posedge clk);
    #1;
    {sec_tick, tone_tick, hrs_adj, min_adj, sec_adj, al_adj, al_toggle} = NONE;
  endtask

  task automatic rep(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) cyc(p);
  endtask

  task automatic expect_out(input string nm, input outs_t v);
    name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  // Monitor: outputs are registered, so one negedge after the pushing edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      outs_t e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {hours, minutes, seconds, al_hours, al_minutes, al_on, ringing, buzzer};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %0d:%0d:%0d al=%0d:%0d on=%b ring=%b buz=%b, expected %0d:%0d:%0d al=%0d:%0d on=%b ring=%b buz=%b",
                 nm, a.hours, a.minutes, a.seconds, a.al_hours, a.al_minutes, a.al_on, a.ringing, a.buzzer,
                 e.hours, e.minutes, e.seconds, e.al_hours, e.al_minutes, e.al_on, e.ringing, e.buzzer);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rep(NONE, 2);
    expect_out("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // Time setting, wraps and rollover
    cyc(HA);      expect_out("hrs_adj_1", mk(1, 0, 0, 0, 0, 0, 0, 0));
    rep(HA, 10);  expect_out("hrs_adj_11", mk(11, 0, 0, 0, 0, 0, 0, 0));
    rep(MA, 59);  expect_out("min_59", mk(11, 59, 0, 0, 0, 0, 0, 0));
    cyc(MA);      expect_out("min_wrap_nocarry", mk(11, 0, 0, 0, 0, 0, 0, 0));
    rep(MA, 59);
    rep(SA, 59);  expect_out("sec_59", mk(11, 59, 59, 0, 0, 0, 0, 0));
    cyc(SA);      expect_out("sec_wrap_nocarry", mk(11, 59, 0, 0, 0, 0, 0, 0));
    rep(SA, 58);  expect_out("set_115958", mk(11, 59, 58, 0, 0, 0, 0, 0));
    cyc(ST);      expect_out("tick_115959", mk(11, 59, 59, 0, 0, 0, 0, 0));
    cyc(ST);      expect_out("tick_rollover", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Priority between simultaneous pulses
    rep(HA, 3); rep(MA, 10); rep(SA, 20);
    expect_out("set_031020", mk(3, 10, 20, 0, 0, 0, 0, 0));
    cyc(ST | MA); expect_out("prio_tick_over_min", mk(3, 10, 21, 0, 0, 0, 0, 0));
    cyc(SA | HA); expect_out("prio_sadj_over_hadj", mk(3, 10, 22, 0, 0, 0, 0, 0));

    // Alarm setpoint stepping
    cyc(ST | AA); expect_out("al_adj_with_tick", mk(3, 10, 23, 0, 10, 0, 0, 0));
    rep(AA, 5);   expect_out("al_1h", mk(3, 10, 23, 1, 0, 0, 0, 0));
    rep(AA, 65);  expect_out("al_1150", mk(3, 10, 23, 11, 50, 0, 0, 0));
    cyc(AA);      expect_out("al_wrap", mk(3, 10, 23, 0, 0, 0, 0, 0));

    // Arm, toggle-wins-over-match, match via manual adjust
    cyc(AT);      expect_out("arm", mk(3, 10, 23, 0, 0, 1, 0, 0));
    cyc(AA);      expect_out("al_0010", mk(3, 10, 23, 0, 10, 1, 0, 0));
    rep(HA, 9);   expect_out("hrs_wrap", mk(0, 10, 23, 0, 10, 1, 0, 0));
    rep(SA, 36);  expect_out("armed_0010_59", mk(0, 10, 59, 0, 10, 1, 0, 0));
    cyc(SA | AT); expect_out("toggle_wins", mk(0, 10, 0, 0, 10, 0, 0, 0));
    cyc(AT);      expect_out("rearm", mk(0, 10, 0, 0, 10, 1, 0, 0));
    rep(SA, 59);
    cyc(SA);      expect_out("match_ring", mk(0, 10, 0, 0, 10, 1, 1, 0));

    // Ringing: beat gating, setpoint change, auto-stop after 3 ticks
    cyc(TT);      expect_out("ring_beat0_silent", mk(0, 10, 0, 0, 10, 1, 1, 0));
    rep(NONE, 3);
    cyc(ST);      expect_out("beat_hi_buzz", mk(0, 10, 1, 0, 10, 1, 1, 1));
    rep(NONE, 3);
    cyc(TT | AA); expect_out("al_adj_while_ring", mk(0, 10, 1, 0, 20, 1, 1, 0));
    rep(NONE, 3);
    cyc(TT);      expect_out("tone_hi_buzz", mk(0, 10, 1, 0, 20, 1, 1, 1));
    cyc(ST);      expect_out("beat_lo_quiet", mk(0, 10, 2, 0, 20, 1, 1, 0));
    rep(NONE, 3);
    cyc(ST);      expect_out("auto_stop", mk(0, 10, 3, 0, 20, 1, 0, 0));
    cyc(ST);      expect_out("no_retrigger", mk(0, 10, 4, 0, 20, 1, 0, 0));

    // Second ring, stopped by al_toggle
    rep(MA, 10);
    rep(SA, 55);  expect_out("armed_0020_59", mk(0, 20, 59, 0, 20, 1, 0, 0));
    cyc(SA);      expect_out("match_ring2", mk(0, 20, 0, 0, 20, 1, 1, 0));
    cyc(ST);
    cyc(TT);      expect_out("buzz2", mk(0, 20, 1, 0, 20, 1, 1, 1));
    cyc(AT);      expect_out("toggle_stop", mk(0, 20, 1, 0, 20, 0, 0, 0));

    // Third ring at 5:20, reset while buzzing at 5:23:40
    rep(AA, 30);  expect_out("al_0520", mk(0, 20, 1, 5, 20, 0, 0, 0));
    cyc(AT);
    rep(HA, 5);
    rep(SA, 59);  expect_out("match_ring3", mk(5, 20, 0, 5, 20, 1, 1, 0));
    rep(MA, 3);
    rep(SA, 39);
    cyc(ST);
    cyc(TT);      expect_out("ring_buzz_052340", mk(5, 23, 40, 5, 20, 1, 1, 1));
    reset = 1'b1;
    cyc(NONE);    expect_out("reset_mid_ring", mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    cyc(AT);      expect_out("post_reset_arm", mk(0, 0, 0, 0, 0, 1, 0, 0));

    rep(NONE, 2);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Upstream stage of the VGA clock face renderer. Keeps the current 12-hour time (h/m/s) and the alarm setpoint.
- Applies debounced adjustment pulses and runs the alarm state machine with an auto-timeout.
- Produces the gated buzzer waveform.
- Its time and alarm outputs feed the renderer's hour/minute/second/al_hour/al_minute inputs directly. All values are always in range; the renderer never sees 60 or 12.

Parameters:
- RING_SECONDS, 60, number of sec_tick pulses the alarm rings before auto-stop (1..255).
- AL_STEP_MIN, 10, minutes added to the alarm setpoint per al_adj pulse (must divide 60).

Ports:
- clk  in  1  system clock (31.5 MHz).
- reset  in  1  synchronous, active-high reset.
- sec_tick  in  1  one-cycle pulse, 1 Hz.
- tone_tick  in  1  one-cycle pulse at the buzzer half-period rate.
- hrs_adj  in  1  debounced one-cycle pulse.
- min_adj  in  1  debounced one-cycle pulse.
- sec_adj  in  1  debounced one-cycle pulse.
- al_adj  in  1  debounced one-cycle pulse.
- al_toggle  in  1  debounced one-cycle pulse.
- hours  out  4  0..11.
- minutes  out  6  0..59.
- seconds  out  6  0..59.
- al_hours  out  4  0..11.
- al_minutes  out  6  0..59, multiple of AL_STEP_MIN.
- al_on  out  1  alarm armed or ringing (drives the bell icon).
- ringing  out  1  alarm currently ringing.
- buzzer  out  1  square-wave drive, needs an external driver.

Behaviour:
- All state is registered on posedge clk. Outputs come directly from flops; there is no combinational path from input to output.
- Reset (synchronous, active-high, takes priority over everything):
  - All counters = 0.
  - FSM = OFF.
  - tone flop = 0, beat flop = 0, ring counter = 0.
  - All outputs = 0.
- Time update, at most one action per cycle, priority sec_tick > sec_adj > min_adj > hrs_adj. A lower-priority pulse in the same cycle is dropped.
- sec_tick:
  - seconds +1.
  - 59 -> 0 with minute carry.
  - Minute 59 -> 0 with hour carry.
  - Hour 11 -> 0.
  - Full ripple completes in the same cycle (11:59:59 -> 0:00:00 in one tick).
- sec_adj: seconds +1, wraps 59 -> 0, no carry.
- min_adj: minutes +1, wraps 59 -> 0, no carry.
- hrs_adj: hours +1, wraps 11 -> 0.
- al_adj (independent of time update, may coincide with any of the above):
  - al_minutes += AL_STEP_MIN.
  - On reaching 60: al_minutes = 0 and al_hours +1 (11 -> 0).
- Alarm FSM, states OFF, ARMED, RINGING:
  - OFF --al_toggle--> ARMED.
  - ARMED --al_toggle--> OFF.
  - ARMED --match--> RINGING. match = next-state time equals al_hours:al_minutes:00, evaluated on the cycle the time register updates. A manual adjust landing exactly on the setpoint with seconds==0 also triggers.
  - RINGING --al_toggle--> OFF.
  - RINGING --ring counter reaches RING_SECONDS sec_ticks--> ARMED. Does not retrigger, because seconds has left 00.
  - al_toggle coinciding with match in ARMED: toggle wins, state -> OFF.
  - Changing the alarm setpoint while RINGING does not stop ringing.
- Ring counter:
  - Cleared on entry to RINGING.
  - +1 per sec_tick while RINGING.
- Outputs from the FSM:
  - al_on = (state != OFF).
  - ringing = (state == RINGING).
- Buzzer:
  - beat flop toggles on each sec_tick while RINGING.
  - tone flop toggles on each tone_tick while RINGING.
  - buzzer = ringing & beat & tone.
  - On leaving RINGING, beat and tone clear in the same cycle, so buzzer is 0 the next cycle.
  - beat = 0 on entry to RINGING, so the first second of ringing is silent.
- Latency: every pulse is reflected on the outputs 1 cycle later.

Decomposition:
- Shared package clock_pkg holds:
  - Widths: HOUR_W=4, MIN_W=6, SEC_W=6.
  - Limits: HOURS_MAX=11, MIN_MAX=59, SEC_MAX=59.
  - Alarm state enum {AL_OFF, AL_ARMED, AL_RINGING}.
- One natural sub-module: mod_counter (parameterised modulus, width; inc, carry_out, wrap). It is instanced for sec, min and hour.
- Alarm setpoint and FSM stay inline.

Test Plan:
- Set 11:59:58 via adjust pulses, then issue 2 sec_ticks -> 11:59:59, then 0:00:00 on the same cycle as the 2nd tick +1.
- sec_tick and min_adj in the same cycle at 3:10:20 -> 3:10:21; minutes unchanged.
- Press al_adj 6 times from reset -> al 1:00; 72 presses total -> al back to 0:00.
- al_toggle, set alarm 0:10, then advance time to 0:10:00 -> ringing=1 the next cycle. RING_SECONDS=3: after 3 sec_ticks ringing=0 and al_on=1; no retrigger at 0:10:03.
- While RINGING, pulse tone_tick every 4 cycles -> buzzer toggles only in beat-high seconds. al_toggle -> ringing=0, al_on=0, buzzer=0 the next cycle.
- Assert reset mid-ring at 5:23:40 -> all outputs 0 the next cycle; FSM OFF.
